// File: rtl/nx_tcam_lkp_pkg.sv
// Shared types, defaults and width helpers for the TCAM lookup-port arbiter.
package nx_tcam_lkp_pkg;

  localparam int LOOKUP_LATENCY_DEF = 3;
  localparam int MAX_BURST_DEF      = 8;
  // Widest index the result record can carry (N_ENTRIES up to 128k).
  localparam int AIDX_MAX_BITS      = 16;

  typedef struct packed {
    logic                     match;
    logic [AIDX_MAX_BITS-1:0] aindex;
  } tcam_lkp_rsp_t;

  // The TCAM reports a pair index, hence N_ENTRIES/2 addressable results.
  function automatic int aidx_bits(input int n_entries);
    return (n_entries > 2) ? $clog2(n_entries / 2) : 1;
  endfunction

endpackage

// File: rtl/nx_tcam_lkp_rr_arb.sv
// Round-robin arbiter: search starts one past the last granted requester.
module nx_tcam_lkp_rr_arb
  import nx_tcam_lkp_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] last_grant;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    idx       = last_grant;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + PTR_W'(1);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  // Pointer moves only when the grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PTR_W'(N_REQ - 1);
    end else if (advance && found) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/nx_tcam_lookup_arbiter.sv
// Shares the TCAM hardware lookup port between N_REQ requesters, bounds lookup
// bursts while software commands wait, and routes results back by ID.
module nx_tcam_lookup_arbiter
  import nx_tcam_lkp_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int KEY_BITS       = 256,
  parameter int N_ENTRIES      = 512,
  parameter int LOOKUP_LATENCY = LOOKUP_LATENCY_DEF,
  parameter int MAX_BURST      = MAX_BURST_DEF,
  localparam int AIDX_BITS     = aidx_bits(N_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lkp_en,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [KEY_BITS-1:0]  req_key [N_REQ],
  output logic [N_REQ-1:0]     req_ready,
  output logic                 tcam_ce,
  output logic [KEY_BITS-1:0]  tcam_key,
  input  logic                 tcam_match,
  input  logic [AIDX_BITS-1:0] tcam_aindex,
  input  logic                 tcam_yield,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic                 rsp_match,
  output logic [AIDX_BITS-1:0] rsp_aindex,
  output logic                 idle,
  output logic [31:0]          lookup_count,
  output logic [31:0]          yield_stall_count
);

  // Handshake: a requester's lookup is taken in the cycle where
  // req_valid[i] && req_ready[i]; req_ready is one-hot and there is no result backpressure.

  localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BURST_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  logic                 stall;
  logic                 issue_ok;
  logic                 handshake;
  logic [N_REQ-1:0]     grant;
  logic [BURST_W-1:0]   burst_cnt;
  logic [KEY_BITS-1:0]  key_sel;
  logic [ID_W-1:0]      id_sel;
  logic [ID_W-1:0]      ce_id;
  logic [LOOKUP_LATENCY-1:0] pipe_vld;
  logic [ID_W-1:0]      pipe_id [LOOKUP_LATENCY];
  tcam_lkp_rsp_t        rsp_q;

  // A full burst with software waiting forces one lookup-free cycle.
  assign stall     = tcam_yield && (MAX_BURST != 0) && (burst_cnt == BURST_MAX);
  assign issue_ok  = rst_n && lkp_en && !stall;
  assign handshake = |grant;
  assign req_ready = grant;

  nx_tcam_lkp_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid & {N_REQ{issue_ok}}),
    .advance (handshake),
    .grant   (grant)
  );

  always_comb begin
    key_sel = '0;
    id_sel  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        key_sel = req_key[i];
        id_sel  = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcam_ce  <= 1'b0;
      tcam_key <= '0;
      ce_id    <= '0;
    end else begin
      tcam_ce <= handshake;
      if (handshake) begin
        tcam_key <= key_sel;
        ce_id    <= id_sel;
      end
    end
  end

  // ID pipe is fed from the strobe stage so its tail lines up with the TCAM result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < LOOKUP_LATENCY; i++) pipe_id[i] <= '0;
    end else begin
      pipe_vld[0] <= tcam_ce;
      pipe_id[0]  <= ce_id;
      for (int i = 1; i < LOOKUP_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_q     <= '0;
    end else begin
      rsp_valid <= pipe_vld[LOOKUP_LATENCY-1] ?
                   (N_REQ'(1) << pipe_id[LOOKUP_LATENCY-1]) : '0;
      if (pipe_vld[LOOKUP_LATENCY-1]) begin
        rsp_q.match  <= tcam_match;
        rsp_q.aindex <= AIDX_MAX_BITS'(tcam_aindex);
      end
    end
  end

  assign rsp_match  = rsp_q.match;
  assign rsp_aindex = AIDX_BITS'(rsp_q.aindex);
  assign idle       = !tcam_ce && !(|pipe_vld) && !(|rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt         <= '0;
      lookup_count      <= '0;
      yield_stall_count <= '0;
    end else begin
      if (handshake) begin
        lookup_count <= lookup_count + 32'd1;
        if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + BURST_W'(1);
      end else begin
        burst_cnt <= '0;
      end
      if (stall && (|req_valid) && lkp_en && (yield_stall_count != 32'hFFFF_FFFF)) begin
        yield_stall_count <= yield_stall_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_nx_tcam_lookup_arbiter.sv
// Randomized scoreboard bench for nx_tcam_lookup_arbiter with a behavioural
// arbitration model and a fixed-latency TCAM responder.
module tb_nx_tcam_lookup_arbiter;

  localparam int N    = 4;
  localparam int KB   = 256;
  localparam int NE   = 512;
  localparam int LAT  = 3;
  localparam int MAXB = 8;
  localparam int AW   = 8;
  localparam int W    = 32 + N + 1 + AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          lkp_en = 1'b0;
  logic          tcam_yield = 1'b0;
  logic          tcam_match = 1'b0;
  logic [AW-1:0] tcam_aindex = '0;
  logic [N-1:0]  req_valid = '0;
  logic [KB-1:0] req_key [N];

  logic [N-1:0]  req_ready, rsp_valid;
  logic          tcam_ce, rsp_match, idle;
  logic [KB-1:0] tcam_key;
  logic [AW-1:0] rsp_aindex;
  logic [31:0]   lookup_count, yield_stall_count;

  logic [N-1:0]  req_ready_nb, rsp_valid_nb;
  logic          tcam_ce_nb, rsp_match_nb, idle_nb;
  logic [KB-1:0] tcam_key_nb;
  logic [AW-1:0] rsp_aindex_nb;
  logic [31:0]   lookup_count_nb, yield_stall_count_nb;

  nx_tcam_lookup_arbiter #(
    .N_REQ(N), .KEY_BITS(KB), .N_ENTRIES(NE), .LOOKUP_LATENCY(LAT), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lkp_en(lkp_en), .req_valid(req_valid), .req_key(req_key),
    .req_ready(req_ready), .tcam_ce(tcam_ce), .tcam_key(tcam_key), .tcam_match(tcam_match),
    .tcam_aindex(tcam_aindex), .tcam_yield(tcam_yield), .rsp_valid(rsp_valid),
    .rsp_match(rsp_match), .rsp_aindex(rsp_aindex), .idle(idle),
    .lookup_count(lookup_count), .yield_stall_count(yield_stall_count)
  );

  // Same inputs, burst limit disabled.
  nx_tcam_lookup_arbiter #(
    .N_REQ(N), .KEY_BITS(KB), .N_ENTRIES(NE), .LOOKUP_LATENCY(LAT), .MAX_BURST(0)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .lkp_en(lkp_en), .req_valid(req_valid), .req_key(req_key),
    .req_ready(req_ready_nb), .tcam_ce(tcam_ce_nb), .tcam_key(tcam_key_nb),
    .tcam_match(tcam_match), .tcam_aindex(tcam_aindex), .tcam_yield(tcam_yield),
    .rsp_valid(rsp_valid_nb), .rsp_match(rsp_match_nb), .rsp_aindex(rsp_aindex_nb),
    .idle(idle_nb), .lookup_count(lookup_count_nb), .yield_stall_count(yield_stall_count_nb)
  );

  // ---------------- TCAM responder: match=key[8], aindex=key[7:0] ----------------
  logic [AW:0] tq[$];
  logic [AW:0] tq_out;
  always @(negedge clk) begin
    tq.push_back(tcam_ce ? {tcam_key[8], tcam_key[7:0]} : (AW+1)'($urandom()));
    if (tq.size() > LAT) begin
      tq_out      = tq.pop_front();
      tcam_match  = tq_out[AW];
      tcam_aindex = tq_out[AW-1:0];
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  task automatic check(input string name, input logic [KB-1:0] act, input logic [KB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, '0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_cycle",  cyc,        mon_e[W-1 -: 32]);
        check("rsp_valid",  rsp_valid,  mon_e[AW+N:AW+1]);
        check("rsp_match",  rsp_match,  mon_e[AW]);
        check("rsp_aindex", rsp_aindex, mon_e[AW-1:0]);
      end
    end else if (rst_n && exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) < cyc) begin
      mon_e = exp_q.pop_front();
      check("rsp_missing", rsp_valid, mon_e[AW+N:AW+1]);
    end
  end

  // ---------------- reference model state ----------------
  int m_last = N - 1;
  int m_burst = 0;
  int m_lookups = 0;
  int m_stalls = 0;
  int m_last_hs = -100;
  logic [KB-1:0] m_last_key = '0;

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic [N-1:0] v, input logic en, input logic y);
    int g;
    logic stl;
    logic [N-1:0] exp_rdy;
    req_valid  = v;
    lkp_en     = en;
    tcam_yield = y;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < KB / 32; j++) req_key[i][j*32 +: 32] = $urandom();
    #1;
    check("tcam_ce", tcam_ce, (m_last_hs == cyc - 1));
    if (m_last_hs == cyc - 1) check("tcam_key", tcam_key, m_last_key);
    check("idle", idle, !(cyc >= m_last_hs + 1 && cyc <= m_last_hs + 2 + LAT));
    check("lookup_count", lookup_count, m_lookups);
    check("yield_stall_count", yield_stall_count, m_stalls);
    stl = y && (MAXB != 0) && (m_burst == MAXB);
    g = -1;
    if (en && !stl)
      for (int k = 1; k <= N; k++)
        if (g < 0 && v[(m_last + k) % N]) g = (m_last + k) % N;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    if (g >= 0) begin
      exp_q.push_back({32'(cyc + 2 + LAT), exp_rdy, req_key[g][8], req_key[g][7:0]});
      m_last     = g;
      m_burst    = (m_burst < MAXB) ? m_burst + 1 : MAXB;
      m_lookups++;
      m_last_hs  = cyc;
      m_last_key = req_key[g];
    end else begin
      m_burst = 0;
    end
    if (stl && v != '0 && en) m_stalls++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int hold);
    req_valid = '1;
    lkp_en    = 1'b1;
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_tcam_ce", tcam_ce, 1'b0);
    check("rst_tcam_key", tcam_key, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_match", rsp_match, 1'b0);
    check("rst_rsp_aindex", rsp_aindex, '0);
    check("rst_idle", idle, 1'b1);
    check("rst_lookup_count", lookup_count, '0);
    check("rst_yield_stall_count", yield_stall_count, '0);
    repeat (hold) @(negedge clk);
    rst_n     = 1'b1;
    m_last    = N - 1;
    m_burst   = 0;
    m_lookups = 0;
    m_stalls  = 0;
    m_last_hs = cyc - 100;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int nb_lc0;
  initial begin
    for (int i = 0; i < N; i++) req_key[i] = '0;
    @(negedge clk);
    do_reset(3);

    // Plain round robin, then drain with lkp_en low.
    repeat (8) drive_cycle('1, 1'b1, 1'b0);
    repeat (8) drive_cycle('1, 1'b0, 1'b0);

    // Single requester.
    repeat (4) drive_cycle(4'b0100, 1'b1, 1'b0);
    repeat (2) drive_cycle('0, 1'b1, 1'b0);

    // Yield with continuous demand: burst limit on dut, none on dut_nb.
    repeat (8) drive_cycle('0, 1'b1, 1'b0);
    nb_lc0 = lookup_count_nb;
    repeat (36) drive_cycle('1, 1'b1, 1'b1);
    check("nb_lookups_during_yield", lookup_count_nb - nb_lc0, 36);
    check("nb_yield_stall_count", yield_stall_count_nb, '0);

    // Yield rises while the burst counter is already saturated.
    repeat (10) drive_cycle('1, 1'b1, 1'b0);
    repeat (4) drive_cycle('1, 1'b1, 1'b1);

    // Three in flight, then lkp_en drops.
    repeat (3) drive_cycle('1, 1'b1, 1'b0);
    repeat (8) drive_cycle('1, 1'b0, 1'b0);

    // Random traffic.
    repeat (400) drive_cycle(N'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0),
                             1'($urandom_range(0, 1)));

    // Reset with lookups in flight.
    repeat (3) drive_cycle('1, 1'b1, 1'b0);
    do_reset(2);
    repeat (6) drive_cycle('1, 1'b1, 1'b0);
    repeat (10) drive_cycle('1, 1'b0, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
